best_nonce_arbiter: RTL and testbench
=====================================

// Module: best_nonce_arbiter
// PURPOSE
//  Shares the single best-result path between N_CORES hash cores. Grants one valid core result at a time, round-robin.
//  Compares the granted result against the running global best (fewest bits off) and keeps the better one.
//  Offers each new global best to serial_interface over a valid/ready handshake.
//  Sits between the core array and serial_interface, replacing the per-core best_nonce/best_bits_off wiring.
// PARAMETERS
//  N_CORES     4    number of requesting cores (>=1)
//  NONCE_W     256  nonce width in bits
//  BITS_OFF_W  10   bits-off score width in bits
// PORTS
//  clk_i            in   1                   clock
//  rst_i            in   1                   reset; asynchronous, active-high
//  reset_best_i     in   1                   synchronous clear of the global best (from serial_interface)
//  core_valid_i     in   N_CORES             core k has a result; held until its core_ready_o[k]
//  core_ready_o     out  N_CORES             grant/accept strobe, at most one bit high per cycle
//  core_nonce_i     in   N_CORES*NONCE_W     core k nonce in slice [k*NONCE_W +: NONCE_W]
//  core_bits_off_i  in   N_CORES*BITS_OFF_W  core k score in slice [k*BITS_OFF_W +: BITS_OFF_W]
//  best_nonce_o     out  NONCE_W             global best nonce
//  best_bits_off_o  out  BITS_OFF_W          global best score
//  best_core_o      out  CORE_W              index of the core that produced the best; CORE_W = max(1, $clog2(N_CORES))
//  report_valid_o   out  1                   new best offered to the serial interface
//  report_ready_i   in   1                   serial interface accepts the report
// BEHAVIOUR
//  Reset values:
//   - best_bits_off_o = all ones; best_nonce_o = 0; best_core_o = 0.
//   - report_valid_o = 0; core_ready_o = 0; rr_ptr = 0; state = IDLE.
//  State IDLE:
//   - If any core_valid_i is high, grant the first valid core at or after rr_ptr (wrapping): core g.
//   - core_ready_o[g] = 1 for exactly that cycle (combinational from state/valid/rr_ptr).
//   - Capture core g's nonce and score into cand regs; rr_ptr <= (g+1) mod N_CORES; go to COMPARE.
//   - If no core is valid, stay in IDLE.
//  State COMPARE:
//   - If cand_bits < best_bits_off_o (strict; a tie keeps the incumbent): load best_* from cand, set report_valid_o, go to REPORT.
//   - Otherwise go to IDLE.
//  State REPORT:
//   - report_valid_o = 1 and best_* held stable.
//   - On report_ready_i: clear report_valid_o in the next cycle and go to IDLE.
//   - No grants are made in REPORT; cores stall with valid held.
//  Latency:
//   - Grant at cycle T; best_* updated and report_valid_o high at T+2.
//   - Minimum grant spacing is 2 cycles when no report is raised.
//  reset_best_i has priority over everything, in every state:
//   - Next cycle: best_* at reset values, report_valid_o = 0, state = IDLE.
//   - A cand in COMPARE is discarded; rr_ptr is kept.
//   - No grant is made in a cycle where reset_best_i is high.
//  Other rules:
//   - An all-ones score can never become best.
//   - N_CORES = 1 degenerates to a single grant path; rr_ptr stays 0.
//   - rst_i mid-handshake drops any pending report and cand immediately.
// CONFIGURATION
//  BEST_NONCE_THRESHOLD_EN defined:
//   - Adds input threshold_i[BITS_OFF_W-1:0].
//   - COMPARE still updates best_*, but raises report_valid_o only if the new best <= threshold_i; otherwise goes to IDLE silently.
//  BEST_NONCE_THRESHOLD_EN undefined:
//   - The port is absent; every improvement is reported.
// STRUCTURE
//  Shared package skein_pkg:
//   - NONCE_W, BITS_OFF_W, BITS_OFF_MAX (all ones).
//   - arb_state_t enum {IDLE, COMPARE, REPORT}.
//  Sub-module rr_picker:
//   - Combinational round-robin priority encoder.
//   - Inputs: request vector and rr_ptr. Outputs: one-hot grant, grant index, any_req.
//  All best/cand/pointer regs are in this module.
// TESTING
//  1. Reset with all valids low -> best_bits_off_o=0x3FF, report_valid_o=0, core_ready_o=0.
//  2. Core 2 valid, bits=37, nonce=0xABCD; report_ready_i=1 -> core_ready_o=4'b0100 at T; report_valid_o at T+2 with bits 37, core 2.
//  3. All 4 valids held with bits 50,40,40,60 -> grant order 0,1,2,3,0; best ends at 40 from core 1 (tie with core 2 is not reported).
//  4. report_ready_i=0 for 10 cycles while core 3 is valid -> core_ready_o stays 0 until the report is accepted; best_* stable.
//  5. reset_best_i pulsed in COMPARE with cand bits 5 -> cand dropped, best=0x3FF, no report; next grant follows rr_ptr.
//  6. (BEST_NONCE_THRESHOLD_EN) threshold=20, results 30 then 15 -> best=30 with no report, then best=15 reported.

Source files
------------

// File: rtl/skein_pkg.sv
// ============================================================================
// Module      : skein_pkg
// Description : Shared widths, score limit and arbiter state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package skein_pkg;

    localparam int NONCE_W    = 256;
    localparam int BITS_OFF_W = 10;
    localparam logic [BITS_OFF_W-1:0] BITS_OFF_MAX = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        REPORT  = 2'd2
    } arb_state_t;

endpackage : skein_pkg

`default_nettype wire

// File: rtl/best_nonce_arbiter_rr_picker.sv
// ============================================================================
// Module      : rr_picker
// Description : Combinational round-robin priority encoder; first request at
//               or after the pointer wins, wrapping around.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_picker #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any_req
);

    int k;

    always_comb begin
        grant   = '0;
        idx     = '0;
        any_req = 1'b0;
        k       = 0;
        for (int i = 0; i < N; i++) begin
            k = (int'(ptr) + i) % N;
            if (!any_req && req[k]) begin
                any_req  = 1'b1;
                grant[k] = 1'b1;
                idx      = IDX_W'(k);
            end
        end
    end

endmodule : rr_picker

`default_nettype wire

// File: rtl/best_nonce_arbiter.sv
// ============================================================================
// Module      : best_nonce_arbiter
// Description : Round-robin arbitration of core results into a single global
//               best, offered to the serial interface via valid/ready.
//               Optional macro BEST_NONCE_THRESHOLD_EN gates reports by score.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module best_nonce_arbiter #(
    parameter int N_CORES    = 4,
    parameter int NONCE_W    = skein_pkg::NONCE_W,
    parameter int BITS_OFF_W = skein_pkg::BITS_OFF_W,
    parameter int CORE_W     = (N_CORES > 1) ? $clog2(N_CORES) : 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          reset_best_i,
    input  logic [N_CORES-1:0]            core_valid_i,
    output logic [N_CORES-1:0]            core_ready_o,
    input  logic [N_CORES*NONCE_W-1:0]    core_nonce_i,
    input  logic [N_CORES*BITS_OFF_W-1:0] core_bits_off_i,
    output logic [NONCE_W-1:0]            best_nonce_o,
    output logic [BITS_OFF_W-1:0]         best_bits_off_o,
    output logic [CORE_W-1:0]             best_core_o,
    output logic                          report_valid_o,
`ifdef BEST_NONCE_THRESHOLD_EN
    input  logic [BITS_OFF_W-1:0]         threshold_i,
`endif
    input  logic                          report_ready_i
);

    import skein_pkg::*;

    arb_state_t            state;
    logic [CORE_W-1:0]     rr_ptr;
    logic [NONCE_W-1:0]    cand_nonce;
    logic [BITS_OFF_W-1:0] cand_bits;
    logic [CORE_W-1:0]     cand_core;

    logic [N_CORES-1:0]    grant;
    logic [CORE_W-1:0]     grant_idx;
    logic                  any_req;
    logic                  grant_en;

    rr_picker #(
        .N     (N_CORES),
        .IDX_W (CORE_W)
    ) u_picker (
        .req     (core_valid_i),
        .ptr     (rr_ptr),
        .grant   (grant),
        .idx     (grant_idx),
        .any_req (any_req)
    );

    // A pending reset_best_i suppresses the grant so no result is lost.
    assign grant_en     = (state == IDLE) && !reset_best_i;
    assign core_ready_o = grant_en ? grant : '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state           <= IDLE;
            rr_ptr          <= '0;
            cand_nonce      <= '0;
            cand_bits       <= '1;
            cand_core       <= '0;
            best_nonce_o    <= '0;
            best_bits_off_o <= '1;
            best_core_o     <= '0;
            report_valid_o  <= 1'b0;
        end else if (reset_best_i) begin
            state           <= IDLE;
            best_nonce_o    <= '0;
            best_bits_off_o <= '1;
            best_core_o     <= '0;
            report_valid_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        cand_nonce <= core_nonce_i[int'(grant_idx)*NONCE_W +: NONCE_W];
                        cand_bits  <= core_bits_off_i[int'(grant_idx)*BITS_OFF_W +: BITS_OFF_W];
                        cand_core  <= grant_idx;
                        rr_ptr     <= (int'(grant_idx) == N_CORES-1) ? '0 : grant_idx + 1'b1;
                        state      <= COMPARE;
                    end
                end
                COMPARE: begin
                    // Strict compare: ties and all-ones scores never displace the incumbent.
                    if (cand_bits < best_bits_off_o) begin
                        best_nonce_o    <= cand_nonce;
                        best_bits_off_o <= cand_bits;
                        best_core_o     <= cand_core;
`ifdef BEST_NONCE_THRESHOLD_EN
                        if (cand_bits <= threshold_i) begin
                            report_valid_o <= 1'b1;
                            state          <= REPORT;
                        end else begin
                            state <= IDLE;
                        end
`else
                        report_valid_o <= 1'b1;
                        state          <= REPORT;
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                REPORT: begin
                    if (report_ready_i) begin
                        report_valid_o <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: begin
                    state          <= IDLE;
                    report_valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule : best_nonce_arbiter

`default_nettype wire

// File: tb/tb_best_nonce_arbiter.sv
// ============================================================================
// Module      : tb_best_nonce_arbiter
// Description : Directed self-checking bench with a report scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_best_nonce_arbiter;

    localparam int N  = 4;
    localparam int NW = 256;
    localparam int BW = 10;
    localparam int CW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              reset_best;
    logic [N-1:0]      core_valid;
    logic [N-1:0]      core_ready;
    logic [N*NW-1:0]   core_nonce;
    logic [N*BW-1:0]   core_bits;
    logic [NW-1:0]     best_nonce;
    logic [BW-1:0]     best_bits;
    logic [CW-1:0]     best_core;
    logic              report_valid;
    logic              report_ready;
    logic [BW-1:0]     threshold;

    typedef struct {
        logic [BW-1:0] bits;
        logic [NW-1:0] nonce;
        logic [CW-1:0] core;
    } rpt_t;

    rpt_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    best_nonce_arbiter #(
        .N_CORES    (N),
        .NONCE_W    (NW),
        .BITS_OFF_W (BW)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .reset_best_i    (reset_best),
        .core_valid_i    (core_valid),
        .core_ready_o    (core_ready),
        .core_nonce_i    (core_nonce),
        .core_bits_off_i (core_bits),
        .best_nonce_o    (best_nonce),
        .best_bits_off_o (best_bits),
        .best_core_o     (best_core),
        .report_valid_o  (report_valid),
`ifdef BEST_NONCE_THRESHOLD_EN
        .threshold_i     (threshold),
`endif
        .report_ready_i  (report_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [NW-1:0] obs, input logic [NW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int k, input logic [BW-1:0] bits, input logic [NW-1:0] nonce);
        core_valid[k]            = 1'b1;
        core_bits[k*BW +: BW]    = bits;
        core_nonce[k*NW +: NW]   = nonce;
    endtask

    // Waits (bounded) for a grant, then checks it is the expected one-hot.
    task automatic wait_grant(input int exp_core, input string tag);
        logic [N-1:0] exp_oh;
        exp_oh = '0;
        exp_oh[exp_core] = 1'b1;
        #1;
        for (int i = 0; i < 40; i++) begin
            if (core_ready != '0) break;
            step();
        end
        chk(tag, NW'(core_ready), NW'(exp_oh));
    endtask

    task automatic expect_report(input int k, input logic [BW-1:0] bits, input logic [NW-1:0] nonce);
        rpt_t r;
        r.bits  = bits;
        r.nonce = nonce;
        r.core  = CW'(k);
        sb.push_back(r);
    endtask

    // Handshake completes at the next rising edge; inputs are stable here.
    always @(negedge clk) begin
        if (!rst && report_valid && report_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_report", NW'(1), NW'(0));
            end else begin
                rpt_t r;
                r = sb.pop_front();
                chk("rpt_bits",  NW'(best_bits), NW'(r.bits));
                chk("rpt_nonce", best_nonce,     r.nonce);
                chk("rpt_core",  NW'(best_core), NW'(r.core));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        reset_best   = 1'b0;
        core_valid   = '0;
        core_nonce   = '0;
        core_bits    = '0;
        report_ready = 1'b1;
        threshold    = 10'd20;
        step(); step();
        rst = 1'b0;
        step();

        // Reset state
        chk("rst_best_bits",  NW'(best_bits),    NW'(10'h3FF));
        chk("rst_best_nonce", best_nonce,        '0);
        chk("rst_best_core",  NW'(best_core),    NW'(0));
        chk("rst_rpt_valid",  NW'(report_valid), NW'(0));
        chk("rst_ready",      NW'(core_ready),   NW'(0));

        // Single core 2 result; report two cycles after the grant
        drive(2, 10'd37, 256'hABCD);
        wait_grant(2, "t2_grant");
        expect_report(2, 10'd37, 256'hABCD);
        step();
        core_valid = '0;
        step();
        chk("t2_rpt_valid", NW'(report_valid), NW'(1));
        chk("t2_bits",      NW'(best_bits),    NW'(37));
        chk("t2_core",      NW'(best_core),    NW'(2));
        step();
        chk("t2_rpt_clear", NW'(report_valid), NW'(0));

        // Round-robin with all cores held valid; rr_ptr restarted by rst
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive(0, 10'd50, 256'h1000);
        drive(1, 10'd40, 256'h1001);
        drive(2, 10'd40, 256'h1002);
        drive(3, 10'd60, 256'h1003);
        wait_grant(0, "t3_grant0");
        expect_report(0, 10'd50, 256'h1000);
        step();
        wait_grant(1, "t3_grant1");
        expect_report(1, 10'd40, 256'h1001);
        step();
        wait_grant(2, "t3_grant2");
        step();
        wait_grant(3, "t3_grant3");
        step();
        wait_grant(0, "t3_grant0b");
        step();
        core_valid = '0;
        step();
        chk("t3_best_bits", NW'(best_bits),    NW'(40));
        chk("t3_best_core", NW'(best_core),    NW'(1));
        chk("t3_nonce",     best_nonce,        256'h1001);
        chk("t3_rpt_valid", NW'(report_valid), NW'(0));

        // Report back-pressure stalls further grants
        report_ready = 1'b0;
        drive(0, 10'd20, 256'h2000);
        wait_grant(0, "t4_grant0");
        expect_report(0, 10'd20, 256'h2000);
        step();
        core_valid = '0;
        drive(3, 10'd10, 256'h2003);
        step();
        for (int i = 0; i < 10; i++) begin
            chk("t4_stall_ready", NW'(core_ready),   NW'(0));
            chk("t4_stall_valid", NW'(report_valid), NW'(1));
            chk("t4_stall_bits",  NW'(best_bits),    NW'(20));
            step();
        end
        report_ready = 1'b1;
        step();
        wait_grant(3, "t4_grant3");
        expect_report(3, 10'd10, 256'h2003);
        step();
        core_valid = '0;
        step(); step(); step();

        // reset_best in COMPARE discards the candidate; rr_ptr survives
        drive(1, 10'd5, 256'h3001);
        wait_grant(1, "t5_grant1");
        step();
        reset_best = 1'b1;
        core_valid = '0;
        #1;
        chk("t5_no_grant_cmp", NW'(core_ready), NW'(0));
        step();
        reset_best = 1'b0;
        chk("t5_best_bits",  NW'(best_bits),    NW'(10'h3FF));
        chk("t5_best_nonce", best_nonce,        '0);
        chk("t5_rpt_valid",  NW'(report_valid), NW'(0));
        drive(0, 10'd100, 256'h3100);
        drive(2, 10'd200, 256'h3200);
        wait_grant(2, "t5_grant_ptr");
        expect_report(2, 10'd200, 256'h3200);
        step();
        core_valid = '0;
        step(); step(); step();
        chk("t5_best_after", NW'(best_bits), NW'(200));

        // No grant while reset_best is asserted in IDLE
        drive(0, 10'd7, 256'h3300);
        reset_best = 1'b1;
        #1;
        chk("t5_no_grant_idle", NW'(core_ready), NW'(0));
        step();
        reset_best = 1'b0;
        core_valid = '0;
        chk("t5_cleared", NW'(best_bits), NW'(10'h3FF));
        step();

`ifdef BEST_NONCE_THRESHOLD_EN
        // Silent improvement above threshold, reported improvement at/below it
        threshold = 10'd20;
        drive(3, 10'd30, 256'h4003);
        wait_grant(3, "t6_grant3");
        step();
        core_valid = '0;
        step();
        chk("t6_best30",   NW'(best_bits),    NW'(30));
        chk("t6_silent",   NW'(report_valid), NW'(0));
        drive(0, 10'd15, 256'h4000);
        wait_grant(0, "t6_grant0");
        expect_report(0, 10'd15, 256'h4000);
        step();
        core_valid = '0;
        step();
        chk("t6_best15",   NW'(best_bits),    NW'(15));
        chk("t6_reported", NW'(report_valid), NW'(1));
        step(); step();
`endif

        chk("sb_drained", NW'(sb.size()), NW'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_best_nonce_arbiter

`default_nettype wire
